// File: rtl/bullet_ctrl_if.sv
// Signal bundle between the bullet controller and its environment
// (fire handshake, slot state, and the sprite-ROM scan side).
interface bullet_ctrl_if #(
    parameter int N_BULLETS = 4
);
    logic                      frame_tick;
    logic                      fire;
    logic [9:0]                fire_x;
    logic [9:0]                fire_y;
    logic                      fire_dir;
    logic                      fire_ack;
    logic                      fire_drop;
    logic [N_BULLETS-1:0]      hit_clr;
    logic [N_BULLETS-1:0]      active;
    logic [10*N_BULLETS-1:0]   pos_x;
    logic [10*N_BULLETS-1:0]   pos_y;
    logic [9:0]                pix_x;
    logic [9:0]                pix_y;
    logic                      video_on;
    logic [2:0]                spr_x;
    logic [2:0]                spr_y;
    logic                      spr_en;
    logic                      spr_data;
    logic                      bullet_pixel;
    logic [2:0]                bullet_id;

    // fire is a single-cycle request; exactly one of fire_ack/fire_drop
    // pulses on the following cycle, there is no back-pressure.
    modport slave (
        input  frame_tick, fire, fire_x, fire_y, fire_dir, hit_clr,
               pix_x, pix_y, video_on, spr_data,
        output fire_ack, fire_drop, active, pos_x, pos_y,
               spr_x, spr_y, spr_en, bullet_pixel, bullet_id
    );

    modport master (
        output frame_tick, fire, fire_x, fire_y, fire_dir, hit_clr,
               pix_x, pix_y, video_on, spr_data,
        input  fire_ack, fire_drop, active, pos_x, pos_y,
               spr_x, spr_y, spr_en, bullet_pixel, bullet_id
    );
endinterface

// File: rtl/bullet_ctrl.sv
// Bullet slot allocator, per-frame mover and 2-stage sprite scan pipeline.
// Optional fire cooldown is enabled with the BULLET_COOLDOWN_EN macro.
module bullet_ctrl #(
    parameter int N_BULLETS = 4,
    parameter int SPEED     = 4,
    parameter int V_RES     = 480,
    parameter int SPR       = 6,
    parameter int COOLDOWN  = 8
) (
    input logic           clk,
    input logic           rst,
    bullet_ctrl_if.slave  bus
);
    logic [N_BULLETS-1:0] active_q, active_d;
    logic [N_BULLETS-1:0] dir_q, dir_d;
    logic [9:0]           x_q [N_BULLETS];
    logic [9:0]           x_d [N_BULLETS];
    logic [9:0]           y_q [N_BULLETS];
    logic [9:0]           y_d [N_BULLETS];
    logic                 ack_q, ack_d;
    logic                 drop_q, drop_d;

    logic [N_BULLETS-1:0] load_sel;
    logic                 free_found;
    logic                 cd_ok;
    logic                 accept;

    logic                 spr_en_q, spr_en_d;
    logic [2:0]           spr_x_q, spr_x_d;
    logic [2:0]           spr_y_q, spr_y_d;
    logic [2:0]           id_q, id_d;
    logic                 pix_q;
    logic [2:0]           bid_q;

    // Free slot is picked from the registered mask, so a slot freed by
    // hit_clr this cycle only becomes allocatable next cycle.
    always_comb begin
        load_sel   = '0;
        free_found = 1'b0;
        for (int i = 0; i < N_BULLETS; i++) begin
            if (!active_q[i] && !free_found) begin
                load_sel[i] = 1'b1;
                free_found  = 1'b1;
            end
        end
    end

    assign accept = bus.fire && free_found && cd_ok;
    assign ack_d  = accept;
    assign drop_d = bus.fire && !accept;

`ifdef BULLET_COOLDOWN_EN
    logic [7:0] cd_q, cd_d;

    assign cd_ok = (cd_q == 8'd0);

    always_comb begin
        cd_d = cd_q;
        if (accept) begin
            cd_d = 8'(COOLDOWN);
        end else if (bus.frame_tick && cd_q != 8'd0) begin
            cd_d = cd_q - 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) cd_q <= 8'd0;
        else     cd_q <= cd_d;
    end
`else
    // No cooldown gating in this build; the comparison only keeps the
    // parameter referenced.
    assign cd_ok = (COOLDOWN >= 0);
`endif

    // Per-slot priority: load, then kill, then frame motion.
    always_comb begin
        logic [10:0] y_down;
        for (int i = 0; i < N_BULLETS; i++) begin
            active_d[i] = active_q[i];
            dir_d[i]    = dir_q[i];
            x_d[i]      = x_q[i];
            y_d[i]      = y_q[i];
            y_down      = {1'b0, y_q[i]} + 11'(SPEED);
            if (accept && load_sel[i]) begin
                active_d[i] = 1'b1;
                dir_d[i]    = bus.fire_dir;
                x_d[i]      = bus.fire_x;
                y_d[i]      = bus.fire_y;
            end else if (bus.hit_clr[i]) begin
                active_d[i] = 1'b0;
            end else if (bus.frame_tick && active_q[i]) begin
                if (!dir_q[i]) begin
                    if (y_q[i] < 10'(SPEED)) active_d[i] = 1'b0;
                    else                     y_d[i] = y_q[i] - 10'(SPEED);
                end else begin
                    if (y_down > 11'(V_RES - SPR)) active_d[i] = 1'b0;
                    else                           y_d[i] = y_down[9:0];
                end
            end
        end
    end

    // Unsigned differences: a pixel left of / above the sprite wraps large.
    always_comb begin
        logic [9:0] dx;
        logic [9:0] dy;
        logic       hit;
        hit      = 1'b0;
        spr_x_d  = 3'd0;
        spr_y_d  = 3'd0;
        id_d     = 3'd0;
        for (int i = N_BULLETS - 1; i >= 0; i--) begin
            dx = bus.pix_x - x_q[i];
            dy = bus.pix_y - y_q[i];
            if (active_q[i] && dx < 10'(SPR) && dy < 10'(SPR)) begin
                hit     = 1'b1;
                spr_x_d = dx[2:0];
                spr_y_d = dy[2:0];
                id_d    = 3'(i);
            end
        end
        spr_en_d = bus.video_on && hit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= '0;
            dir_q    <= '0;
            for (int i = 0; i < N_BULLETS; i++) begin
                x_q[i] <= 10'd0;
                y_q[i] <= 10'd0;
            end
            ack_q    <= 1'b0;
            drop_q   <= 1'b0;
            spr_en_q <= 1'b0;
            spr_x_q  <= 3'd0;
            spr_y_q  <= 3'd0;
            id_q     <= 3'd0;
            pix_q    <= 1'b0;
            bid_q    <= 3'd0;
        end else begin
            active_q <= active_d;
            dir_q    <= dir_d;
            for (int i = 0; i < N_BULLETS; i++) begin
                x_q[i] <= x_d[i];
                y_q[i] <= y_d[i];
            end
            ack_q    <= ack_d;
            drop_q   <= drop_d;
            spr_en_q <= spr_en_d;
            spr_x_q  <= spr_x_d;
            spr_y_q  <= spr_y_d;
            id_q     <= id_d;
            pix_q    <= spr_en_q && bus.spr_data;
            bid_q    <= id_q;
        end
    end

    for (genvar g = 0; g < N_BULLETS; g++) begin : g_pos
        assign bus.pos_x[10*g +: 10] = x_q[g];
        assign bus.pos_y[10*g +: 10] = y_q[g];
    end

    assign bus.active       = active_q;
    assign bus.fire_ack     = ack_q;
    assign bus.fire_drop    = drop_q;
    assign bus.spr_en       = spr_en_q;
    assign bus.spr_x        = spr_x_q;
    assign bus.spr_y        = spr_y_q;
    assign bus.bullet_pixel = pix_q;
    assign bus.bullet_id    = bid_q;
endmodule

// File: tb/tb_bullet_ctrl.sv
// Directed, table-driven bench for bullet_ctrl: slot allocation/motion table,
// streamed scan-pipeline table, and hand-written reset/cooldown sequences.
module tb_bullet_ctrl;
    localparam int N = 4;
`ifdef BULLET_COOLDOWN_EN
    localparam int CD_MAIN = 0;
`else
    localparam int CD_MAIN = 8;
`endif

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    bullet_ctrl_if #(.N_BULLETS(N)) bus ();

    bullet_ctrl #(
        .N_BULLETS(N), .SPEED(4), .V_RES(480), .SPR(6), .COOLDOWN(CD_MAIN)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ROM model: every pixel opaque except the bottom-right corner.
    function automatic logic rom_bit(input logic [2:0] x, input logic [2:0] y);
        return !(x == 3'd5 && y == 3'd5);
    endfunction

    assign bus.spr_data = rom_bit(bus.spr_x, bus.spr_y);

    typedef struct {
        logic       tick;
        logic       fire;
        logic [9:0] fx;
        logic [9:0] fy;
        logic       dir;
        logic [3:0] hit;
        logic       ack;
        logic       drop;
        logic [3:0] act;
        int         slot;
        logic [9:0] ex;
        logic [9:0] ey;
    } seq_t;

    typedef struct {
        logic [9:0] px;
        logic [9:0] py;
        logic       von;
        logic       en;
        logic [2:0] sx;
        logic [2:0] sy;
        logic [2:0] id;
        logic       pix;
    } scan_t;

    seq_t  seq [18];
    scan_t scn [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.frame_tick = 1'b0;
        bus.fire       = 1'b0;
        bus.fire_x     = 10'd0;
        bus.fire_y     = 10'd0;
        bus.fire_dir   = 1'b0;
        bus.hit_clr    = '0;
    endtask

    task automatic do_fire(input logic [9:0] x, input logic [9:0] y, input logic d);
        bus.fire   = 1'b1;
        bus.fire_x = x;
        bus.fire_y = y;
        bus.fire_dir = d;
        cycle();
        bus.fire   = 1'b0;
    endtask

`ifdef BULLET_COOLDOWN_EN
    bullet_ctrl_if #(.N_BULLETS(N)) bus2 ();

    bullet_ctrl #(
        .N_BULLETS(N), .SPEED(4), .V_RES(480), .SPR(6), .COOLDOWN(2)
    ) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    assign bus2.spr_data = 1'b0;

    task automatic cd_step(input logic f, input logic t, input logic eack, input logic edrop,
                           input string name);
        bus2.fire       = f;
        bus2.frame_tick = t;
        cycle();
        bus2.fire       = 1'b0;
        bus2.frame_tick = 1'b0;
        check({name, "_ack"}, 32'(bus2.fire_ack), 32'(eack));
        check({name, "_drop"}, 32'(bus2.fire_drop), 32'(edrop));
    endtask
`endif

    initial begin
        // tick fire  fx      fy      dir  hit      ack  drop act      slot ex      ey
        seq[0]  = '{0, 1, 10'd100, 10'd200, 0, 4'b0000, 1, 0, 4'b0001, 0, 10'd100, 10'd200};
        seq[1]  = '{1, 0, 10'd0,   10'd0,   0, 4'b0000, 0, 0, 4'b0001, 0, 10'd100, 10'd196};
        seq[2]  = '{1, 0, 10'd0,   10'd0,   0, 4'b0000, 0, 0, 4'b0001, 0, 10'd100, 10'd192};
        seq[3]  = '{1, 0, 10'd0,   10'd0,   0, 4'b0000, 0, 0, 4'b0001, 0, 10'd100, 10'd188};
        seq[4]  = '{0, 1, 10'd10,  10'd3,   0, 4'b0000, 1, 0, 4'b0011, 1, 10'd10,  10'd3};
        seq[5]  = '{1, 0, 10'd0,   10'd0,   0, 4'b0000, 0, 0, 4'b0001, 0, 10'd100, 10'd184};
        seq[6]  = '{0, 1, 10'd20,  10'd470, 1, 4'b0000, 1, 0, 4'b0011, 1, 10'd20,  10'd470};
        seq[7]  = '{1, 0, 10'd0,   10'd0,   0, 4'b0000, 0, 0, 4'b0011, 1, 10'd20,  10'd474};
        seq[8]  = '{1, 0, 10'd0,   10'd0,   0, 4'b0000, 0, 0, 4'b0001, 0, 10'd100, 10'd176};
        seq[9]  = '{0, 1, 10'd30,  10'd50,  1, 4'b0000, 1, 0, 4'b0011, 1, 10'd30,  10'd50};
        seq[10] = '{0, 1, 10'd40,  10'd60,  0, 4'b0000, 1, 0, 4'b0111, 2, 10'd40,  10'd60};
        seq[11] = '{0, 1, 10'd50,  10'd70,  0, 4'b0000, 1, 0, 4'b1111, 3, 10'd50,  10'd70};
        seq[12] = '{0, 1, 10'd9,   10'd9,   0, 4'b0000, 0, 1, 4'b1111, 3, 10'd50,  10'd70};
        seq[13] = '{1, 1, 10'd9,   10'd9,   0, 4'b0001, 0, 1, 4'b1110, 3, 10'd50,  10'd66};
        seq[14] = '{0, 1, 10'd5,   10'd300, 1, 4'b0000, 1, 0, 4'b1111, 0, 10'd5,   10'd300};
        seq[15] = '{0, 0, 10'd0,   10'd0,   0, 4'b0010, 0, 0, 4'b1101, 0, 10'd5,   10'd300};
        seq[16] = '{1, 1, 10'd60,  10'd100, 0, 4'b0000, 1, 0, 4'b1111, 1, 10'd60,  10'd100};
        seq[17] = '{0, 0, 10'd0,   10'd0,   0, 4'b1111, 0, 0, 4'b0000, -1, 10'd0,  10'd0};

        // Bullets at slot0 (100,200) and slot1 (101,201) during the scan table.
        //        px       py       von en  sx    sy    id    pix
        scn[0] = '{10'd102, 10'd203, 1, 1, 3'd2, 3'd3, 3'd0, 1};
        scn[1] = '{10'd106, 10'd205, 1, 1, 3'd5, 3'd4, 3'd1, 1};
        scn[2] = '{10'd106, 10'd206, 1, 1, 3'd5, 3'd5, 3'd1, 0};
        scn[3] = '{10'd99,  10'd203, 1, 0, 3'd0, 3'd0, 3'd0, 0};
        scn[4] = '{10'd102, 10'd203, 0, 0, 3'd2, 3'd3, 3'd0, 0};
        scn[5] = '{10'd100, 10'd200, 1, 1, 3'd0, 3'd0, 3'd0, 1};
        scn[6] = '{10'd107, 10'd207, 1, 0, 3'd0, 3'd0, 3'd0, 0};
        scn[7] = '{10'd105, 10'd205, 1, 1, 3'd5, 3'd5, 3'd0, 0};

        // Clock/reset
        idle_inputs();
        bus.pix_x    = 10'd0;
        bus.pix_y    = 10'd0;
        bus.video_on = 1'b0;
`ifdef BULLET_COOLDOWN_EN
        bus2.frame_tick = 1'b0;
        bus2.fire       = 1'b0;
        bus2.fire_x     = 10'd10;
        bus2.fire_y     = 10'd100;
        bus2.fire_dir   = 1'b0;
        bus2.hit_clr    = '0;
        bus2.pix_x      = 10'd0;
        bus2.pix_y      = 10'd0;
        bus2.video_on   = 1'b0;
`endif
        rst = 1'b1;
        cycle();
        cycle();
        check("rst_active", 32'(bus.active), 32'd0);
        check("rst_ack", 32'(bus.fire_ack), 32'd0);
        check("rst_drop", 32'(bus.fire_drop), 32'd0);
        check("rst_pos_y", bus.pos_y, 32'd0);
        check("rst_spr_en", 32'(bus.spr_en), 32'd0);
        check("rst_bullet_pixel", 32'(bus.bullet_pixel), 32'd0);
        rst = 1'b0;

        // Allocation / motion / kill table, one row per clock
        for (int i = 0; i < 18; i++) begin
            bus.frame_tick = seq[i].tick;
            bus.fire       = seq[i].fire;
            bus.fire_x     = seq[i].fx;
            bus.fire_y     = seq[i].fy;
            bus.fire_dir   = seq[i].dir;
            bus.hit_clr    = seq[i].hit;
            cycle();
            check($sformatf("seq%0d_ack", i), 32'(bus.fire_ack), 32'(seq[i].ack));
            check($sformatf("seq%0d_drop", i), 32'(bus.fire_drop), 32'(seq[i].drop));
            check($sformatf("seq%0d_active", i), 32'(bus.active), 32'(seq[i].act));
            if (seq[i].slot >= 0) begin
                check($sformatf("seq%0d_x%0d", i, seq[i].slot),
                      32'(bus.pos_x[10*seq[i].slot +: 10]), 32'(seq[i].ex));
                check($sformatf("seq%0d_y%0d", i, seq[i].slot),
                      32'(bus.pos_y[10*seq[i].slot +: 10]), 32'(seq[i].ey));
            end
        end
        idle_inputs();

        // Scan pipeline: stage 1 checked one edge after the pixel, stage 2 one edge later
        do_fire(10'd100, 10'd200, 1'b0);
        check("scan_fire0_ack", 32'(bus.fire_ack), 32'd1);
        do_fire(10'd101, 10'd201, 1'b0);
        check("scan_fire1_active", 32'(bus.active), 32'b0011);
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) begin
                bus.pix_x    = scn[i].px;
                bus.pix_y    = scn[i].py;
                bus.video_on = scn[i].von;
            end
            cycle();
            if (i < 8) begin
                check($sformatf("scan%0d_spr_en", i), 32'(bus.spr_en), 32'(scn[i].en));
                check($sformatf("scan%0d_spr_x", i), 32'(bus.spr_x), 32'(scn[i].sx));
                check($sformatf("scan%0d_spr_y", i), 32'(bus.spr_y), 32'(scn[i].sy));
            end
            if (i > 0) begin
                check($sformatf("scan%0d_pixel", i - 1), 32'(bus.bullet_pixel), 32'(scn[i-1].pix));
                if (scn[i-1].en)
                    check($sformatf("scan%0d_id", i - 1), 32'(bus.bullet_id), 32'(scn[i-1].id));
            end
        end

        // Reset while a bullet pixel is being drawn
        bus.pix_x    = 10'd102;
        bus.pix_y    = 10'd203;
        bus.video_on = 1'b1;
        cycle();
        cycle();
        check("midrst_pixel_before", 32'(bus.bullet_pixel), 32'd1);
        rst = 1'b1;
        cycle();
        check("midrst_pixel_after", 32'(bus.bullet_pixel), 32'd0);
        check("midrst_active", 32'(bus.active), 32'd0);
        check("midrst_spr_en", 32'(bus.spr_en), 32'd0);
        rst = 1'b0;
        bus.video_on = 1'b0;
        cycle();

`ifdef BULLET_COOLDOWN_EN
        // Cooldown of 2 frame ticks on the second instance
        cd_step(1'b1, 1'b0, 1'b1, 1'b0, "cd_first");
        cd_step(1'b1, 1'b0, 1'b0, 1'b1, "cd_blocked");
        cd_step(1'b0, 1'b1, 1'b0, 1'b0, "cd_tick1");
        cd_step(1'b1, 1'b0, 1'b0, 1'b1, "cd_blocked2");
        cd_step(1'b0, 1'b1, 1'b0, 1'b0, "cd_tick2");
        cd_step(1'b1, 1'b0, 1'b1, 1'b0, "cd_released");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
